// File: rtl/ltc2387_pkg.sv
// ---------------------------------------------------------------------------
// ltc2387_pkg : shared types and constants for the LTC2387 model    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ltc2387_pkg;

  localparam int ADC_WIDTH_DEFAULT = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

  localparam logic [1:0] PAT_EXTERNAL = 2'd0;
  localparam logic [1:0] PAT_RAMP     = 2'd1;
  localparam logic [1:0] PAT_ALT_A    = 2'd2;
  localparam logic [1:0] PAT_ALT_B    = 2'd3;

  localparam logic [17:0] PATTERN_A = 18'h2AAAA;
  localparam logic [17:0] PATTERN_B = 18'h15555;

  // Number of clk edges needed to move a whole sample out.
  function automatic int shift_edges(input logic two_lane, input int width);
    return two_lane ? (width / 2) : width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ltc2387_adc_model_if.sv
// ---------------------------------------------------------------------------
// ltc2387_adc_model_if : FPGA-side ADC pins (cnv/clk out, dco/da/db in) rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ltc2387_adc_model_if;
  logic cnv;
  logic clk;
  logic dco;
  logic da;
  logic db;

  modport master (output cnv, output clk, input dco, input da, input db);
  modport slave  (input cnv, input clk, output dco, output da, output db);
endinterface

`default_nettype wire

// File: rtl/ltc2387_sync_edge.sv
// ---------------------------------------------------------------------------
// ltc2387_sync_edge : multi-flop synchronizer with rise/any-edge detect rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ltc2387_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit ANY_EDGE    = 1'b0
) (
  input  logic sys_clk_int,
  input  logic reset_int,
  input  logic async_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge sys_clk_int) begin
    if (reset_int) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  generate
    if (ANY_EDGE) begin : g_any_edge
      assign edge_det = r_sync[SYNC_STAGES-1] ^ r_hist;
    end else begin : g_rise_edge
      assign edge_det = r_sync[SYNC_STAGES-1] & ~r_hist;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ltc2387_adc_model.sv
// ---------------------------------------------------------------------------
// ltc2387_adc_model : LTC2387 digital-side emulator, 1/2-lane DDR output rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ltc2387_adc_model
  import ltc2387_pkg::*;
#(
  parameter int ADC_WIDTH    = ADC_WIDTH_DEFAULT,
  parameter int SYS_CLK_FREQ = 200_000_000,
  parameter int T_CONV       = int'((64'd60 * 64'(SYS_CLK_FREQ)) / 64'd1_000_000_000),
  parameter int SYNC_STAGES  = 2,
  parameter int RAMP_STEP    = 1
) (
  input  logic                 sys_clk_int,
  input  logic                 reset_int,
  ltc2387_adc_model_if.slave   adc,
  input  logic                 tl,
  input  logic [1:0]           pattern_sel,
  input  logic [ADC_WIDTH-1:0] sample_data,
  input  logic                 clear_overrun,
  output logic                 busy,
  output logic                 overrun,
  output logic [15:0]          conv_count
);

  localparam int CNT_W = (T_CONV > 1) ? $clog2(T_CONV) : 1;
  localparam int BIT_W = $clog2(ADC_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_CONV - 1);

  logic w_cnv_rise;
  logic w_clk_edge;

  ltc2387_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .ANY_EDGE(1'b0)) u_cnv_sync (
    .sys_clk_int (sys_clk_int),
    .reset_int   (reset_int),
    .async_in    (adc.cnv),
    .edge_det    (w_cnv_rise)
  );

  ltc2387_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .ANY_EDGE(1'b1)) u_clk_sync (
    .sys_clk_int (sys_clk_int),
    .reset_int   (reset_int),
    .async_in    (adc.clk),
    .edge_det    (w_clk_edge)
  );

  state_t               r_state,   w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit,     w_bit_nxt;
  logic [ADC_WIDTH-1:0] r_shreg,   w_shreg_nxt;
  logic [ADC_WIDTH-1:0] r_ramp,    w_ramp_nxt;
  logic                 r_tl,      w_tl_nxt;
  logic                 r_pend,    w_pend_nxt;
  logic                 r_dco,     w_dco_nxt;
  logic                 r_da,      w_da_nxt;
  logic                 r_db,      w_db_nxt;
  logic                 r_overrun, w_overrun_nxt;
  logic [15:0]          r_count,   w_count_nxt;
  logic [ADC_WIDTH-1:0] w_shifted;
  logic [BIT_W-1:0]     w_last_bit;

  always_ff @(posedge sys_clk_int) begin
    if (reset_int) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_ramp    <= '0;
      r_tl      <= 1'b0;
      r_pend    <= 1'b0;
      r_dco     <= 1'b0;
      r_da      <= 1'b0;
      r_db      <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      r_ramp    <= w_ramp_nxt;
      r_tl      <= w_tl_nxt;
      r_pend    <= w_pend_nxt;
      r_dco     <= w_dco_nxt;
      r_da      <= w_da_nxt;
      r_db      <= w_db_nxt;
      r_overrun <= w_overrun_nxt;
      r_count   <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_shreg_nxt   = r_shreg;
    w_ramp_nxt    = r_ramp;
    w_tl_nxt      = r_tl;
    w_pend_nxt    = 1'b0;
    w_dco_nxt     = r_dco;
    w_da_nxt      = r_da;
    w_db_nxt      = r_db;
    w_overrun_nxt = r_overrun;
    w_count_nxt   = r_count;
    w_shifted     = r_tl ? {r_shreg[ADC_WIDTH-3:0], 2'b00} : {r_shreg[ADC_WIDTH-2:0], 1'b0};
    w_last_bit    = BIT_W'(shift_edges(r_tl, ADC_WIDTH) - 1);

    // A new overrun event takes priority over a same-cycle clear.
    if (w_cnv_rise && (r_state != ST_IDLE)) begin
      w_overrun_nxt = 1'b1;
    end else if (clear_overrun) begin
      w_overrun_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        w_dco_nxt = 1'b0;
        w_da_nxt  = 1'b0;
        w_db_nxt  = 1'b0;
        if (w_cnv_rise) begin
          w_state_nxt = ST_CONVERT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_tl_nxt    = tl;
          case (pattern_sel)
            PAT_EXTERNAL: w_shreg_nxt = sample_data;
            PAT_RAMP: begin
              w_shreg_nxt = r_ramp;
              w_ramp_nxt  = r_ramp + ADC_WIDTH'(RAMP_STEP);
            end
            PAT_ALT_A:    w_shreg_nxt = ADC_WIDTH'(PATTERN_A);
            default:      w_shreg_nxt = ADC_WIDTH'(PATTERN_B);
          endcase
        end
      end

      ST_CONVERT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_SHIFT;
          w_da_nxt    = r_shreg[ADC_WIDTH-1];
          w_db_nxt    = r_tl ? r_shreg[ADC_WIDTH-2] : 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_SHIFT: begin
        // dco toggles one cycle after the clk edge; data moves a cycle later for hold.
        if (w_clk_edge) begin
          w_dco_nxt  = ~r_dco;
          w_pend_nxt = 1'b1;
        end
        if (r_pend) begin
          if (r_bit == w_last_bit) begin
            w_state_nxt = ST_IDLE;
            w_dco_nxt   = 1'b0;
            w_da_nxt    = 1'b0;
            w_db_nxt    = 1'b0;
            w_count_nxt = r_count + 16'd1;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shreg_nxt = w_shifted;
            w_da_nxt    = w_shifted[ADC_WIDTH-1];
            w_db_nxt    = r_tl ? w_shifted[ADC_WIDTH-2] : 1'b0;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign adc.dco    = r_dco;
  assign adc.da     = r_da;
  assign adc.db     = r_db;
  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_overrun;
  assign conv_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ltc2387_adc_model.sv
// ---------------------------------------------------------------------------
// tb_ltc2387_adc_model : directed scoreboard bench for the LTC2387 model rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ltc2387_adc_model;

  logic        sys_clk_int = 1'b0;
  logic        reset_int;
  logic        tl;
  logic [1:0]  pattern_sel;
  logic [17:0] sample_data;
  logic        clear_overrun;
  logic        busy;
  logic        overrun;
  logic [15:0] conv_count;

  int errors = 0;
  int checks = 0;
  logic [17:0] sb [$];

  always #5 sys_clk_int = ~sys_clk_int;

  ltc2387_adc_model_if adc ();

  ltc2387_adc_model #(
    .ADC_WIDTH    (18),
    .SYS_CLK_FREQ (200_000_000),
    .SYNC_STAGES  (2),
    .RAMP_STEP    (1)
  ) dut (
    .sys_clk_int   (sys_clk_int),
    .reset_int     (reset_int),
    .adc           (adc),
    .tl            (tl),
    .pattern_sel   (pattern_sel),
    .sample_data   (sample_data),
    .clear_overrun (clear_overrun),
    .busy          (busy),
    .overrun       (overrun),
    .conv_count    (conv_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a conversion and queue the sample it should produce.
  task automatic cnv_pulse(input logic [17:0] exp);
    sb.push_back(exp);
    adc.cnv = 1'b1;
    repeat (2) @(negedge sys_clk_int);
    check("busy_before_rise", busy, 0);
    @(negedge sys_clk_int);
    check("busy_after_rise", busy, 1);
    adc.cnv = 1'b0;
  endtask

  task automatic wait_conv();
    repeat (14) @(negedge sys_clk_int);
  endtask

  // Toggle clk n times, capture lanes at each dco change, compare against the scoreboard.
  task automatic shift_word(input int n, input bit two, input int cnv_at, input int abort_after);
    logic [17:0] word;
    bit db_bad, busy_bad, got;
    logic prev;
    word = '0;
    db_bad = 1'b0;
    busy_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == cnv_at) adc.cnv = 1'b1;
      adc.clk = ~adc.clk;
      prev = adc.dco;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge sys_clk_int);
        if (adc.dco !== prev) got = 1'b1;
      end
      if (!got) begin
        check("dco_timeout", got, 1);
        adc.cnv = 1'b0;
        return;
      end
      if (two) begin
        word = {word[15:0], adc.da, adc.db};
      end else begin
        word = {word[16:0], adc.da};
        if (adc.db !== 1'b0) db_bad = 1'b1;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (i == cnv_at) adc.cnv = 1'b0;
      if (i + 1 == abort_after) return;
      repeat (2) @(negedge sys_clk_int);
    end
    check("busy_in_shift", busy_bad, 0);
    if (!two) check("db_zero_one_lane", db_bad, 0);
    check("idle_after_shift", {busy, adc.dco, adc.da, adc.db}, 0);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) check("word", word, sb.pop_front());
  endtask

  initial begin
    bit bad;
    reset_int     = 1'b1;
    tl            = 1'b1;
    pattern_sel   = 2'd0;
    sample_data   = '0;
    clear_overrun = 1'b0;
    adc.cnv       = 1'b0;
    adc.clk       = 1'b0;
    repeat (3) @(negedge sys_clk_int);
    check("reset_outputs", {adc.dco, adc.da, adc.db, busy, overrun}, 0);
    check("reset_count", conv_count, 0);
    reset_int = 1'b0;
    repeat (2) @(negedge sys_clk_int);

    // External word, two lanes
    pattern_sel = 2'd0;
    sample_data = 18'h3A5C3;
    tl = 1'b1;
    cnv_pulse(18'h3A5C3);
    wait_conv();
    shift_word(9, 1'b1, -1, -1);
    check("count_ext", conv_count, 1);

    // Ramp: three conversions
    pattern_sel = 2'd1;
    for (int j = 0; j < 3; j++) begin
      cnv_pulse(18'(j));
      wait_conv();
      shift_word(9, 1'b1, -1, -1);
      repeat (2) @(negedge sys_clk_int);
    end
    check("count_ramp", conv_count, 4);

    // One lane, fixed pattern A
    tl = 1'b0;
    pattern_sel = 2'd2;
    cnv_pulse(18'h2AAAA);
    wait_conv();
    shift_word(18, 1'b0, -1, -1);
    check("count_one_lane", conv_count, 5);

    // Overrun during SHIFT; tl change mid-conversion must not matter
    tl = 1'b1;
    pattern_sel = 2'd3;
    cnv_pulse(18'h15555);
    tl = 1'b0;
    wait_conv();
    shift_word(9, 1'b1, 3, -1);
    tl = 1'b1;
    repeat (4) @(negedge sys_clk_int);
    check("overrun_set", overrun, 1);
    check("count_overrun", conv_count, 6);
    clear_overrun = 1'b1;
    @(negedge sys_clk_int);
    clear_overrun = 1'b0;
    check("overrun_cleared", overrun, 0);

    // clk activity in IDLE and CONVERT is ignored
    pattern_sel = 2'd0;
    sample_data = 18'h00001;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc.clk = ~adc.clk;
      repeat (3) @(negedge sys_clk_int);
      if ({adc.dco, adc.da, adc.db} !== 3'b000) bad = 1'b1;
    end
    repeat (3) @(negedge sys_clk_int);
    check("idle_clk_ignored", bad, 0);
    cnv_pulse(18'h00001);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adc.clk = ~adc.clk;
      repeat (2) @(negedge sys_clk_int);
      if ({adc.dco, adc.da, adc.db} !== 3'b000) bad = 1'b1;
    end
    check("convert_clk_ignored", bad, 0);
    check("busy_in_convert", busy, 1);
    repeat (6) @(negedge sys_clk_int);
    shift_word(9, 1'b1, -1, -1);
    check("count_after_ignore", conv_count, 7);

    // Reset mid-shift, then a clean conversion
    sample_data = 18'h3FFFF;
    cnv_pulse(18'h3FFFF);
    wait_conv();
    shift_word(9, 1'b1, -1, 4);
    reset_int = 1'b1;
    @(negedge sys_clk_int);
    check("midreset_outputs", {adc.dco, adc.da, adc.db, busy, overrun}, 0);
    check("midreset_count", conv_count, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    reset_int = 1'b0;
    repeat (4) @(negedge sys_clk_int);
    cnv_pulse(18'h3FFFF);
    wait_conv();
    shift_word(9, 1'b1, -1, -1);
    check("count_after_reset", conv_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
